// File: rtl/hoplite_packet_pkg.sv
// Shared definitions for the Hoplite packet assembler: default field widths,
// packed-word field offsets, packet width helper and output FSM states.
package hoplite_packet_pkg;

  localparam int DEF_COORD_BITS          = 1;
  localparam int DEF_MULTICAST_BITS      = 1;
  localparam int DEF_MATRIX_TYPE_BITS    = 1;
  localparam int DEF_MATRIX_COORD_BITS   = 8;
  localparam int DEF_MATRIX_ELEMENT_BITS = 32;

  function automatic int calc_packet_bits(input int coord_bits, input int mcast_bits,
                                          input int mtype_bits, input int mcoord_bits,
                                          input int elem_bits);
    return 2 * coord_bits + mcast_bits + 2 + mtype_bits + 2 * mcoord_bits + elem_bits;
  endfunction

  localparam int DEF_PACKET_BITS = calc_packet_bits(DEF_COORD_BITS, DEF_MULTICAST_BITS,
                                                    DEF_MATRIX_TYPE_BITS, DEF_MATRIX_COORD_BITS,
                                                    DEF_MATRIX_ELEMENT_BITS);

  // Field LSB offsets in the default packet word; element sits at bit 0.
  localparam int ELEMENT_LSB   = 0;
  localparam int MATRIX_Y_LSB  = ELEMENT_LSB + DEF_MATRIX_ELEMENT_BITS;
  localparam int MATRIX_X_LSB  = MATRIX_Y_LSB + DEF_MATRIX_COORD_BITS;
  localparam int TYPE_LSB      = MATRIX_X_LSB + DEF_MATRIX_COORD_BITS;
  localparam int RESULT_BIT    = TYPE_LSB + DEF_MATRIX_TYPE_BITS;
  localparam int DONE_BIT      = RESULT_BIT + 1;
  localparam int MULTICAST_LSB = DONE_BIT + 1;
  localparam int Y_LSB         = MULTICAST_LSB + DEF_MULTICAST_BITS;
  localparam int X_LSB         = Y_LSB + DEF_COORD_BITS;

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } out_state_e;

endpackage

// File: rtl/hoplite_packet_assembler_fifo.sv
// Circular-buffer packet FIFO with wrapping pointers and an occupancy count.
// Exposes the head entry and the entry behind it for the registered output stage.
module packet_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head_next,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; clearing pointers and count makes
  // stale entries unreachable, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + PTR_W'(1)];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/hoplite_packet_assembler.sv
// Stages memory-mapped packet fields, commits snapshots into a FIFO and presents
// the head to the Hoplite router. Optional ASSEMBLER_DROP_COUNT_EN adds drop_count.
module hoplite_packet_assembler
  import hoplite_packet_pkg::*;
#(
  parameter  int COORD_BITS           = DEF_COORD_BITS,
  parameter  int MULTICAST_GROUP_BITS = DEF_MULTICAST_BITS,
  parameter  int MATRIX_TYPE_BITS     = DEF_MATRIX_TYPE_BITS,
  parameter  int MATRIX_COORD_BITS    = DEF_MATRIX_COORD_BITS,
  parameter  int MATRIX_ELEMENT_BITS  = DEF_MATRIX_ELEMENT_BITS,
  parameter  int FIFO_DEPTH           = 4,
  localparam int PACKET_BITS = calc_packet_bits(COORD_BITS, MULTICAST_GROUP_BITS,
                                                MATRIX_TYPE_BITS, MATRIX_COORD_BITS,
                                                MATRIX_ELEMENT_BITS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
  input  logic                            multicast_group_in_valid,
  input  logic                            done_flag_in,
  input  logic                            done_flag_in_valid,
  input  logic                            result_flag_in,
  input  logic                            result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
  input  logic                            matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
  input  logic                            matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
  input  logic                            matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
  input  logic                            matrix_element_in_valid,
  input  logic                            packet_complete_in,
  output logic                            message_out_ready,
  output logic [PACKET_BITS-1:0]          packet_out,
  output logic                            packet_out_valid,
  input  logic                            packet_out_ready,
  output logic                            overflow
`ifdef ASSEMBLER_DROP_COUNT_EN
  ,
  output logic [15:0]                     drop_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [COORD_BITS-1:0]           x_q, x_d, y_q, y_d;
  logic [MULTICAST_GROUP_BITS-1:0] mcast_q, mcast_d;
  logic                            done_q, done_d, result_q, result_d;
  logic [MATRIX_TYPE_BITS-1:0]     mtype_q, mtype_d;
  logic [MATRIX_COORD_BITS-1:0]    mx_q, mx_d, my_q, my_d;
  logic [MATRIX_ELEMENT_BITS-1:0]  elem_q, elem_d;
  logic [PACKET_BITS-1:0]          snapshot;

  // Write-through view of the staging registers so a same-cycle write joins the commit.
  assign x_d      = x_coord_in_valid         ? x_coord_in         : x_q;
  assign y_d      = y_coord_in_valid         ? y_coord_in         : y_q;
  assign mcast_d  = multicast_group_in_valid ? multicast_group_in : mcast_q;
  assign done_d   = done_flag_in_valid       ? done_flag_in       : done_q;
  assign result_d = result_flag_in_valid     ? result_flag_in     : result_q;
  assign mtype_d  = matrix_type_in_valid     ? matrix_type_in     : mtype_q;
  assign mx_d     = matrix_x_coord_in_valid  ? matrix_x_coord_in  : mx_q;
  assign my_d     = matrix_y_coord_in_valid  ? matrix_y_coord_in  : my_q;
  assign elem_d   = matrix_element_in_valid  ? matrix_element_in  : elem_q;
  assign snapshot = {x_d, y_d, mcast_d, done_d, result_d, mtype_d, mx_d, my_d, elem_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0; y_q <= '0; mcast_q <= '0; done_q <= 1'b0; result_q <= 1'b0;
      mtype_q <= '0; mx_q <= '0; my_q <= '0; elem_q <= '0;
    end else begin
      x_q <= x_d; y_q <= y_d; mcast_q <= mcast_d; done_q <= done_d; result_q <= result_d;
      mtype_q <= mtype_d; mx_q <= mx_d; my_q <= my_d; elem_q <= elem_d;
    end
  end

  logic                   push, pop, drop;
  logic [PACKET_BITS-1:0] fifo_head, fifo_head_next;
  logic [CNT_W-1:0]       fifo_count, count_next;
  logic                   fifo_full, fifo_empty;

  assign pop        = packet_out_valid && packet_out_ready;
  assign push       = packet_complete_in && (!fifo_full || pop);
  assign drop       = packet_complete_in && !push;
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  packet_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .wdata     (snapshot),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  out_state_e             state_q, state_d;
  logic [PACKET_BITS-1:0] head_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    head_d  = packet_out;
    unique case (state_q)
      EMPTY: begin
        if (!fifo_empty) begin
          state_d = PRESENT;
          head_d  = fifo_head;
        end
      end
      PRESENT: begin
        // A pop at count 1 with a simultaneous push forwards the new snapshot.
        if (pop) begin
          if (fifo_count > CNT_W'(1)) head_d = fifo_head_next;
          else if (push)             head_d = snapshot;
          else                       state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= EMPTY;
      packet_out        <= '0;
      message_out_ready <= 1'b1;
      overflow          <= 1'b0;
    end else begin
      state_q           <= state_d;
      packet_out        <= head_d;
      message_out_ready <= (count_next < CNT_W'(FIFO_DEPTH));
      if (drop) overflow <= 1'b1;
    end
  end

  assign packet_out_valid = (state_q == PRESENT);

`ifdef ASSEMBLER_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                             drop_count <= 16'd0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hoplite_packet_assembler.sv
// Directed self-checking bench for hoplite_packet_assembler (default widths, depth 4).
// drop_count checks are compiled in only with ASSEMBLER_DROP_COUNT_EN.
module tb_hoplite_packet_assembler;

  localparam int PB = 54;

  logic          clk = 1'b0;
  logic          reset;
  logic          x_coord_in, x_coord_in_valid, y_coord_in, y_coord_in_valid;
  logic          multicast_group_in, multicast_group_in_valid;
  logic          done_flag_in, done_flag_in_valid, result_flag_in, result_flag_in_valid;
  logic          matrix_type_in, matrix_type_in_valid;
  logic [7:0]    matrix_x_coord_in, matrix_y_coord_in;
  logic          matrix_x_coord_in_valid, matrix_y_coord_in_valid;
  logic [31:0]   matrix_element_in;
  logic          matrix_element_in_valid;
  logic          packet_complete_in;
  logic          message_out_ready;
  logic [PB-1:0] packet_out;
  logic          packet_out_valid;
  logic          packet_out_ready;
  logic          overflow;
`ifdef ASSEMBLER_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  hoplite_packet_assembler dut (
    .clk                      (clk),
    .reset                    (reset),
    .x_coord_in               (x_coord_in),
    .x_coord_in_valid         (x_coord_in_valid),
    .y_coord_in               (y_coord_in),
    .y_coord_in_valid         (y_coord_in_valid),
    .multicast_group_in       (multicast_group_in),
    .multicast_group_in_valid (multicast_group_in_valid),
    .done_flag_in             (done_flag_in),
    .done_flag_in_valid       (done_flag_in_valid),
    .result_flag_in           (result_flag_in),
    .result_flag_in_valid     (result_flag_in_valid),
    .matrix_type_in           (matrix_type_in),
    .matrix_type_in_valid     (matrix_type_in_valid),
    .matrix_x_coord_in        (matrix_x_coord_in),
    .matrix_x_coord_in_valid  (matrix_x_coord_in_valid),
    .matrix_y_coord_in        (matrix_y_coord_in),
    .matrix_y_coord_in_valid  (matrix_y_coord_in_valid),
    .matrix_element_in        (matrix_element_in),
    .matrix_element_in_valid  (matrix_element_in_valid),
    .packet_complete_in       (packet_complete_in),
    .message_out_ready        (message_out_ready),
    .packet_out               (packet_out),
    .packet_out_valid         (packet_out_valid),
    .packet_out_ready         (packet_out_ready),
    .overflow                 (overflow)
`ifdef ASSEMBLER_DROP_COUNT_EN
    ,
    .drop_count               (drop_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [PB-1:0] make_pkt(input logic x, input logic y, input logic mc,
                                             input logic dn, input logic rs, input logic ty,
                                             input logic [7:0] mx, input logic [7:0] my,
                                             input logic [31:0] el);
    return {x, y, mc, dn, rs, ty, mx, my, el};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    x_coord_in_valid = 0; y_coord_in_valid = 0; multicast_group_in_valid = 0;
    done_flag_in_valid = 0; result_flag_in_valid = 0; matrix_type_in_valid = 0;
    matrix_x_coord_in_valid = 0; matrix_y_coord_in_valid = 0; matrix_element_in_valid = 0;
    packet_complete_in = 0;
  endtask

  initial begin
    reset = 1;
    x_coord_in = 0; y_coord_in = 0; multicast_group_in = 0; done_flag_in = 0;
    result_flag_in = 0; matrix_type_in = 0; matrix_x_coord_in = 0; matrix_y_coord_in = 0;
    matrix_element_in = 0; packet_out_ready = 0;
    clear_writes();
    tick(); tick();
    check("rst_valid", 64'(packet_out_valid), 64'd0);
    check("rst_packet", 64'(packet_out), 64'd0);
    check("rst_msg_ready", 64'(message_out_ready), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
`ifdef ASSEMBLER_DROP_COUNT_EN
    check("rst_drop_count", 64'(drop_count), 64'd0);
`endif
    reset = 0;

    // Single packet x=1, element DEADBEEF, ready held high.
    packet_out_ready = 1;
    x_coord_in = 1; x_coord_in_valid = 1; y_coord_in = 0; y_coord_in_valid = 1;
    matrix_element_in = 32'hDEADBEEF; matrix_element_in_valid = 1;
    tick();
    clear_writes(); packet_complete_in = 1;
    tick();
    check("t1_not_yet_valid", 64'(packet_out_valid), 64'd0);
    packet_complete_in = 0;
    tick();
    check("t1_valid", 64'(packet_out_valid), 64'd1);
    check("t1_packet", 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 32'hDEADBEEF)));
    tick();
    check("t1_single_pulse", 64'(packet_out_valid), 64'd0);
    check("t1_msg_ready", 64'(message_out_ready), 64'd1);

    // Sticky fields: repeat commit, then commit writing only element=5.
    packet_complete_in = 1;
    tick();
    check("t2_first_latency", 64'(packet_out_valid), 64'd0);
    matrix_element_in = 32'd5; matrix_element_in_valid = 1;
    tick();
    clear_writes();
    check("t2_first_packet", 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 32'hDEADBEEF)));
    tick();
    check("t2_second_valid", 64'(packet_out_valid), 64'd1);
    check("t2_second_packet", 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'd0, 8'd0, 32'd5)));
    tick();
    check("t2_drained", 64'(packet_out_valid), 64'd0);

    // Field write in the commit cycle joins that packet.
    matrix_x_coord_in = 8'h07; matrix_x_coord_in_valid = 1; packet_complete_in = 1;
    tick();
    clear_writes();
    tick();
    check("t3_packet", 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'h07, 8'd0, 32'd5)));
    tick();
    check("t3_drained", 64'(packet_out_valid), 64'd0);

    // Pop of the last entry while a new commit lands: head stays valid.
    matrix_element_in = 32'd30; matrix_element_in_valid = 1; packet_complete_in = 1;
    tick();
    clear_writes();
    tick();
    check("t_byp_first", 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'h07, 8'd0, 32'd30)));
    matrix_element_in = 32'd31; matrix_element_in_valid = 1; packet_complete_in = 1;
    tick();
    clear_writes();
    check("t_byp_valid", 64'(packet_out_valid), 64'd1);
    check("t_byp_next", 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'h07, 8'd0, 32'd31)));
    tick();
    check("t_byp_drained", 64'(packet_out_valid), 64'd0);

    // Fill with ready low, overflow on the fifth commit, then drain in order.
    packet_out_ready = 0;
    check("t4_no_overflow_yet", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) begin
      matrix_element_in = 32'(i); matrix_element_in_valid = 1; packet_complete_in = 1;
      tick();
      check($sformatf("t4_msg_ready_%0d", i), 64'(message_out_ready), (i < 3) ? 64'd1 : 64'd0);
    end
    matrix_element_in_valid = 0;
    tick();
    packet_complete_in = 0;
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_full_msg_ready", 64'(message_out_ready), 64'd0);
`ifdef ASSEMBLER_DROP_COUNT_EN
    check("t4_drop_count", 64'(drop_count), 64'd1);
`endif
    check("t4_head0", 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'h07, 8'd0, 32'd0)));
    packet_out_ready = 1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("t4_head%0d", i), 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'h07, 8'd0, 32'(i))));
    end
    check("t4_msg_ready_after_pop", 64'(message_out_ready), 64'd1);
    tick();
    check("t4_drained", 64'(packet_out_valid), 64'd0);

    // Full FIFO with simultaneous commit and pop: accepted, count stays at depth.
    packet_out_ready = 0;
    for (int i = 10; i < 14; i++) begin
      matrix_element_in = 32'(i); matrix_element_in_valid = 1; packet_complete_in = 1;
      tick();
    end
    clear_writes();
    check("t5_full", 64'(message_out_ready), 64'd0);
    check("t5_head10", 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'h07, 8'd0, 32'd10)));
    packet_out_ready = 1;
    matrix_element_in = 32'd14; matrix_element_in_valid = 1; packet_complete_in = 1;
    tick();
    clear_writes();
    check("t5_still_full", 64'(message_out_ready), 64'd0);
    check("t5_head11", 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'h07, 8'd0, 32'd11)));
`ifdef ASSEMBLER_DROP_COUNT_EN
    check("t5_no_drop", 64'(drop_count), 64'd1);
`endif
    for (int i = 12; i < 15; i++) begin
      tick();
      check($sformatf("t5_head%0d", i), 64'(packet_out), 64'(make_pkt(1, 0, 0, 0, 0, 0, 8'h07, 8'd0, 32'(i))));
    end
    tick();
    check("t5_drained", 64'(packet_out_valid), 64'd0);
    check("t5_msg_ready", 64'(message_out_ready), 64'd1);

    // Reset with two entries queued discards them.
    packet_out_ready = 0;
    matrix_element_in = 32'd40; matrix_element_in_valid = 1; packet_complete_in = 1;
    tick();
    matrix_element_in = 32'd41;
    tick();
    clear_writes();
    tick();
    check("t6_queued_valid", 64'(packet_out_valid), 64'd1);
    reset = 1;
    tick();
    check("t6_rst_valid", 64'(packet_out_valid), 64'd0);
    check("t6_rst_msg_ready", 64'(message_out_ready), 64'd1);
    check("t6_rst_overflow", 64'(overflow), 64'd0);
    check("t6_rst_packet", 64'(packet_out), 64'd0);
    reset = 0;
    tick();
    check("t6_stays_empty", 64'(packet_out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
